// File: rtl/alu_cmd_sequencer_if.sv
// Byte-stream command input and result handshake between a producer/consumer
// and the ALU command sequencer.
interface alu_cmd_sequencer_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;

  modport master (
    output in_valid, in_data, res_ready,
    input  in_ready, res_valid, res_data
  );

  modport slave (
    input  in_valid, in_data, res_ready,
    output in_ready, res_valid, res_data
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Assembles two-byte ALU commands, issues registered operands to the external
// combinational ALU, and holds the captured result behind a valid/ready port.
module alu_cmd_sequencer #(
  parameter int unsigned TIMEOUT  = 15,
  parameter logic [3:0]  ACC_INIT = 4'h0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_cmd_sequencer_if.slave    bus,
  output logic [3:0]            alu_a,
  output logic [3:0]            alu_b,
  output logic [3:0]            alu_opcode,
  input  logic [3:0]            alu_out,
  input  logic                  alu_z,
  input  logic                  alu_c,
  output logic [3:0]            acc,
  output logic [7:0]            op_count,
  output logic                  err
);

  localparam int unsigned TIMER_W = 8;

  typedef enum logic [1:0] {
    S_BYTE0 = 2'd0,
    S_BYTE1 = 2'd1,
    S_ISSUE = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [3:0]           hold_a_q;
  logic [3:0]           hold_op_q;
  logic [TIMER_W-1:0]   timer_q;
  logic                 xfer_c;
  logic                 timeout_c;

  assign bus.in_ready = (state_q == S_BYTE0) || (state_q == S_BYTE1);
  assign xfer_c       = bus.in_valid && bus.in_ready;
  // A byte1 arriving on the expiry cycle still wins over the timeout.
  assign timeout_c    = (state_q == S_BYTE1) && !xfer_c &&
                        (timer_q == TIMER_W'(TIMEOUT));

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BYTE0: if (xfer_c) state_d = S_BYTE1;
      S_BYTE1: begin
        if (xfer_c)         state_d = S_ISSUE;
        else if (timeout_c) state_d = S_BYTE0;
      end
      S_ISSUE: state_d = S_HOLD;
      S_HOLD:  if (bus.res_ready) state_d = S_BYTE0;
      default: state_d = S_BYTE0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_BYTE0;
    else        state_q <= state_d;
  end

  // Command holding, operand issue, result capture and bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_a_q      <= '0;
      hold_op_q     <= '0;
      timer_q       <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_opcode    <= '0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      acc           <= ACC_INIT;
      op_count      <= '0;
      err           <= 1'b0;
    end else begin
      case (state_q)
        S_BYTE0: begin
          if (xfer_c) begin
            hold_a_q  <= bus.in_data[7:4];
            hold_op_q <= bus.in_data[3:0];
            timer_q   <= '0;
          end
        end
        S_BYTE1: begin
          if (xfer_c) begin
            alu_opcode <= hold_op_q;
            alu_a      <= bus.in_data[0] ? acc : hold_a_q;
            alu_b      <= bus.in_data[7:4];
          end else if (timeout_c) begin
            err <= 1'b1;
          end else begin
            timer_q <= timer_q + TIMER_W'(1);
          end
        end
        S_ISSUE: begin
          bus.res_data  <= {2'b00, alu_c, alu_z, alu_out};
          acc           <= alu_out;
          op_count      <= op_count + 8'd1;
          bus.res_valid <= 1'b1;
        end
        S_HOLD: begin
          if (bus.res_ready) bus.res_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomized self-checking bench for alu_cmd_sequencer with a transaction-level
// reference model and a behavioural ALU stub.
module tb_alu_cmd_sequencer;

  localparam int unsigned TIMEOUT  = 15;
  localparam logic [3:0]  ACC_INIT = 4'h6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] alu_a, alu_b, alu_opcode, alu_out, acc;
  logic       alu_z, alu_c, err;
  logic [7:0] op_count;

  int total = 0;
  int bad   = 0;

  logic [3:0] acc_m;
  logic [7:0] cnt_m;
  logic       err_m;

  always #5 clk = ~clk;

  alu_cmd_sequencer_if bus();

  alu_cmd_sequencer #(.TIMEOUT(TIMEOUT), .ACC_INIT(ACC_INIT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_out    (alu_out),
    .alu_z      (alu_z),
    .alu_c      (alu_c),
    .acc        (acc),
    .op_count   (op_count),
    .err        (err)
  );

  // ALU behaviour: returns {carry, zero, out}
  function automatic logic [5:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] op);
    logic [4:0] r;
    case (op)
      4'd0:    r = {1'b0, a & b};
      4'd1:    r = {1'b0, a | b};
      4'd2:    r = {1'b0, a ^ b};
      4'd3:    r = {1'b0, ~a};
      4'd4:    r = {1'b0, a} + {1'b0, b};
      4'd5:    r = {1'b0, a} + 5'd1;
      4'd6:    r = {1'b0, a} + {1'b0, ~b} + 5'd1;
      4'd7:    r = {1'b0, a} + 5'h0F;
      4'd8:    r = {a, 1'b0};
      4'd9:    r = {2'b00, a[3:1]};
      4'd10:   r = (a < b) ? 5'd1 : 5'd0;
      default: r = {1'b0, b};
    endcase
    return {r[4], (r[3:0] == 4'd0), r[3:0]};
  endfunction

  always_comb {alu_c, alu_z, alu_out} = alu_fn(alu_a, alu_b, alu_opcode);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a byte and wait (bounded) until the sequencer takes it.
  task automatic send_byte(input logic [7:0] b);
    bit done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
    if (!done) check("byte_accept_timeout", 32'(0), 32'(1));
  endtask

  // One command: byte0, gap idle cycles, byte1 (unless the gap expires),
  // then result observation and consumer handshake.
  task automatic do_cmd(input logic [7:0] b0, input logic [7:0] b1, input int gap,
                        input int hold, input bit keep_rdy, input bit rel);
    logic [3:0] a_exp;
    logic [5:0] r;
    logic [7:0] res_exp;
    bus.res_ready = keep_rdy;
    send_byte(b0);
    idle(gap);
    if (gap > int'(TIMEOUT)) begin
      err_m = 1'b1;
      check("to_err",      32'(err),           32'(err_m));
      check("to_valid",    32'(bus.res_valid), 32'(0));
      check("to_count",    32'(op_count),      32'(cnt_m));
      check("to_in_ready", 32'(bus.in_ready),  32'(1));
      bus.res_ready = 1'b0;
      return;
    end
    a_exp = b1[0] ? acc_m : b0[7:4];
    send_byte(b1);
    check("alu_a",       32'(alu_a),         32'(a_exp));
    check("alu_b",       32'(alu_b),         32'(b1[7:4]));
    check("alu_opcode",  32'(alu_opcode),    32'(b0[3:0]));
    check("early_valid", 32'(bus.res_valid), 32'(0));
    check("issue_ready", 32'(bus.in_ready),  32'(0));
    r       = alu_fn(a_exp, b1[7:4], b0[3:0]);
    res_exp = {2'b00, r};
    acc_m   = r[3:0];
    cnt_m   = cnt_m + 8'd1;
    idle(1);
    check("res_valid",   32'(bus.res_valid), 32'(1));
    check("res_data",    32'(bus.res_data),  32'(res_exp));
    check("acc",         32'(acc),           32'(acc_m));
    check("op_count",    32'(op_count),      32'(cnt_m));
    check("err",         32'(err),           32'(err_m));
    if (keep_rdy) begin
      idle(1);
      check("rdy_release", 32'(bus.res_valid), 32'(0));
      bus.res_ready = 1'b0;
      return;
    end
    repeat (hold) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      idle(1);
      check("hold_in_ready", 32'(bus.in_ready),  32'(0));
      check("hold_valid",    32'(bus.res_valid), 32'(1));
      check("hold_data",     32'(bus.res_data),  32'(res_exp));
    end
    bus.in_valid = 1'b0;
    if (rel) begin
      bus.res_ready = 1'b1;
      idle(1);
      check("release_valid", 32'(bus.res_valid), 32'(0));
      check("release_ready", 32'(bus.in_ready),  32'(1));
      bus.res_ready = 1'b0;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_alu_a"},  32'(alu_a),         32'(0));
    check({tag, "_alu_b"},  32'(alu_b),         32'(0));
    check({tag, "_alu_op"}, 32'(alu_opcode),    32'(0));
    check({tag, "_valid"},  32'(bus.res_valid), 32'(0));
    check({tag, "_data"},   32'(bus.res_data),  32'(0));
    check({tag, "_acc"},    32'(acc),           32'(ACC_INIT));
    check({tag, "_count"},  32'(op_count),      32'(0));
    check({tag, "_err"},    32'(err),           32'(0));
    check({tag, "_ready"},  32'(bus.in_ready),  32'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int gap;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.res_ready = 1'b0;
    acc_m = ACC_INIT;
    cnt_m = 8'd0;
    err_m = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check_reset_state("por");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    do_cmd(8'h34, 8'h50, 0, 0, 1'b0, 1'b1);
    check("t1_res", 32'(bus.res_data), 32'(8'h08));
    check("t1_acc", 32'(acc), 32'(4'h8));

    do_cmd(8'h05, 8'h01, 0, 0, 1'b1, 1'b1);
    check("t2_res", 32'(bus.res_data), 32'(8'h09));

    do_cmd(8'h56, 8'h50, 1, 0, 1'b0, 1'b1);
    check("t3_res", 32'(bus.res_data), 32'(8'h30));
    check("t3_acc", 32'(acc), 32'(4'h0));

    do_cmd(8'h34, 8'h00, int'(TIMEOUT) + 1, 0, 1'b0, 1'b1);
    check("t4_err", 32'(err), 32'(1));
    do_cmd(8'h12, 8'hA0, int'(TIMEOUT), 0, 1'b0, 1'b1);
    do_cmd(8'h78, 8'h31, 2, 10, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      gap = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TIMEOUT - 1, TIMEOUT + 2))
                                        : int'($urandom_range(0, 3));
      do_cmd(8'($urandom), 8'($urandom), gap, int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'b1);
    end

    do_cmd(8'($urandom), 8'($urandom), 0, 2, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    check_reset_state("mid");
    acc_m = ACC_INIT;
    cnt_m = 8'd0;
    err_m = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 256; i++) begin
      do_cmd(8'($urandom), 8'($urandom), int'($urandom_range(0, 2)),
             int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    end
    check("wrap_count", 32'(op_count), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
